// File: rtl/mult_seq_32_21_if.sv
// Operand/result bundle for the sequential shift-and-add multiplier.
interface mult_seq_32_21_if #(
  parameter int A_W = 32,
  parameter int B_W = 21,
  parameter int P_W = A_W + B_W
);
  logic           start;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic [P_W-1:0] product;
  logic           pv;
  logic           busy;

  modport master (output start, output a, output b,
                  input  product, input pv, input busy);
  modport slave  (input  start, input a, input b,
                  output product, output pv, output busy);
endinterface

// File: rtl/mult_seq_32_21.sv
// Unsigned radix-2 shift-and-add multiplier: one partial product per cycle,
// fixed latency of A_W+1 edges from the accepted start to END.
module mult_seq_32_21 #(
  parameter int A_W = 32,
  parameter int B_W = 21,
  parameter int P_W = A_W + B_W
) (
  input  logic             clk,
  input  logic             rst,
  mult_seq_32_21_if.slave  bus
);
  localparam int HI_W  = P_W - A_W + 1;
  localparam int CNT_W = $clog2(A_W + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_END} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [P_W:0]     w_q, w_d;
  logic [P_W:0]     w_add;
  logic [HI_W-1:0]  hi_sum;
  logic [B_W-1:0]   b_reg_q, b_reg_d;
  logic [P_W-1:0]   product_q, product_d;
  logic             pv_q, pv_d;

  // Next-state, datapath step and result capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_d       = w_q;
    b_reg_d   = b_reg_q;
    product_d = product_q;
    pv_d      = 1'b0;

    // Multiplier bits of a are consumed from W[0]; the partial sum
    // accumulates in the upper field, including the carry bit W[P_W].
    hi_sum = w_q[P_W:A_W] + HI_W'(b_reg_q);
    w_add  = w_q;
    if (w_q[0]) begin
      w_add[P_W:A_W] = hi_sum;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          b_reg_d = bus.b;
          w_d     = (P_W+1)'(bus.a);
          cnt_d   = '0;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        w_d   = w_add >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(A_W - 1)) begin
          state_d = ST_END;
        end
      end
      ST_END: begin
        product_d = w_q[P_W-1:0];
        pv_d      = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      w_q       <= '0;
      b_reg_q   <= '0;
      product_q <= '0;
      pv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_q       <= w_d;
      b_reg_q   <= b_reg_d;
      product_q <= product_d;
      pv_q      <= pv_d;
    end
  end

  assign bus.product = product_q;
  assign bus.pv      = pv_q;
  assign bus.busy    = (state_q != ST_IDLE);
endmodule
